// File: rtl/itr_ctrl_if.sv
// I/O port bundle shared between core_fl and the interrupt controller:
// the core's output-write and input-read address/strobe pairs plus the ID readback.
interface itr_ctrl_if #(
    parameter int NBDATA = 23,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8
);
    logic [$clog2(NUIOOU)-1:0] addr_out;
    logic                      out_en;
    logic [$clog2(NUIOIN)-1:0] addr_in;
    logic                      req_in;
    logic [NBDATA-1:0]         io_rdata;
    logic                      io_sel;

    modport master (
        output addr_out, out_en, addr_in, req_in,
        input  io_rdata, io_sel
    );

    modport slave (
        input  addr_out, out_en, addr_in, req_in,
        output io_rdata, io_sel
    );
endinterface

// File: rtl/itr_ctrl.sv
// Edge-triggered interrupt controller for core_fl: synchronizes sources, latches
// pending edges, fires one itr pulse per service and waits for an EOI write.
module itr_ctrl #(
    parameter int NSRC   = 4,
    parameter int NBDATA = 23,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int IDADD  = 7,
    parameter int EOIADD = 5,
    parameter int ENADD  = 6,
    parameter int DISADD = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_in,
    itr_ctrl_if.slave       bus,
    output logic            itr,
    output logic            busy
);
    localparam int IDW = $clog2(NSRC);
    localparam int AOW = $clog2(NUIOOU);
    localparam int AIW = $clog2(NUIOIN);
    localparam logic [AOW-1:0] EOI_A = AOW'(EOIADD);
    localparam logic [AOW-1:0] EN_A  = AOW'(ENADD);
    localparam logic [AOW-1:0] DIS_A = AOW'(DISADD);
    localparam logic [AIW-1:0] ID_A  = AIW'(IDADD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_SERV
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_latch;

    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;
    logic [NSRC-1:0] r_dly;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_clr;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  w_pick;
    logic            r_enable;

    logic            w_eoi_wr;
    logic            w_en_wr;
    logic            w_dis_wr;

    assign w_eoi_wr = bus.out_en && (bus.addr_out == EOI_A);
    assign w_en_wr  = bus.out_en && (bus.addr_out == EN_A);
    assign w_dis_wr = bus.out_en && (bus.addr_out == DIS_A);

    // Two-flop synchronizer plus a delay stage; a rise is seen once per level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_dly   <= '0;
        end else begin
            r_sync1 <= src_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_dly;
    assign w_clr  = (r_state == S_FIRE) ? (NSRC'(1) << r_id) : '0;

    // Lowest index wins.
    always_comb begin
        w_pick = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (r_pending[i]) w_pick = IDW'(i);
        end
    end

    // A fresh edge beats the FIRE clear so the event is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_id      <= '0;
            r_enable  <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_latch) r_id <= w_pick;
            if (w_en_wr)       r_enable <= 1'b1;
            else if (w_dis_wr) r_enable <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable && |r_pending) begin
                    w_state_next = S_FIRE;
                    w_latch      = 1'b1;
                end
            end
            S_FIRE: w_state_next = S_SERV;
            S_SERV: if (w_eoi_wr) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign itr  = (r_state == S_FIRE);
    assign busy = (r_state != S_IDLE);

    // Zero exponent with mantissa = id is the integer id in core float format.
    assign bus.io_rdata = NBDATA'(r_id);
    assign bus.io_sel   = bus.req_in && (bus.addr_in == ID_A);
endmodule
